count_arbiter: RTL
==================

Name: count_arbiter

Overview:
- Shares the single 4-bit LED counting datapath between N_REQ requesters (buttons or upstream blocks).
- Grants one requester at a time, round-robin; the granted requester gets one full counting run 0..MAX_COUNT.
- Issues a one-cycle done pulse to the granted requester, then releases.
- Runs entirely on the board clock; the slow step rate comes from a tick enable, never from a derived clock.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CLK_DIV, 1500000, clk cycles per tick (6 MHz / 1.5 M = 4 Hz step rate); minimum 2
- CNT_W, 4, counter/LED width
- MAX_COUNT, 15, terminal count value; must be < 2**CNT_W

Ports:
- clk  in  1  system clock, 6 MHz
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  request lines, active-high level, already synchronised and debounced
- grant  out  N_REQ  one-hot grant; all zero when idle
- busy  out  1  high whenever state != IDLE
- led  out  CNT_W  current count of the shared counter
- done  out  N_REQ  one-hot, one-clk pulse at end of a run
- tick  out  1  prescaler strobe, one clk wide, for observation

Behaviour:
- Reset: all registers cleared asynchronously.
  - Outputs: grant=0, busy=0, led=0, done=0, tick=0.
  - Internal: prescaler=0, rr_ptr=0, state=IDLE.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0; width $clog2(CLK_DIV).
  - tick is registered, high for the one clk cycle after the count equals CLK_DIV-1.
  - Free-running in every state.
- FSM states: IDLE, COUNT, DONE. All transitions are evaluated only in clk cycles where tick=1. Outputs hold between ticks.
- IDLE:
  - On tick with req!=0, pick the first set bit scanning upward from rr_ptr, wrapping modulo N_REQ.
  - Set the matching grant bit, set led=0, go to COUNT.
  - On tick with req=0: stay in IDLE, led=0.
- COUNT:
  - On tick with led<MAX_COUNT: led<=led+1.
  - On tick with led==MAX_COUNT: go to DONE; led holds MAX_COUNT.
  - A run therefore spans MAX_COUNT+1 ticks in COUNT.
- DONE:
  - done[g] is high for exactly one clk, the cycle after entry.
  - led holds MAX_COUNT and grant is held through the DONE tick period.
  - On the next tick: grant<=0, led<=0, rr_ptr<=(g+1) mod N_REQ, go to IDLE.
- Request handling:
  - req changes during COUNT/DONE are ignored (without the optional feature); a run always completes.
  - A requester still holding req in IDLE competes normally; round-robin prevents starvation.
  - Requests made during DONE are not seen until the first IDLE tick. Minimum gap between runs is 1 tick.
- Illegal state encoding: go to IDLE on the next clk with grant=0 and led=0.
- Reset mid-run: immediate return to reset values; no done pulse is issued.

Optional Feature:
- Macro: COUNT_ARB_ABORT_EN.
- Defined: if req[g] is low on a tick while in COUNT, the run aborts.
  - grant<=0, led<=0, rr_ptr<=(g+1) mod N_REQ, state<=IDLE.
  - No done pulse is issued.
  - Extra output port abort (1 bit) pulses for one clk.
- Undefined: behaviour as above; no abort port.

Decomposition:
- Package count_arbiter_pkg:
  - state typedef (IDLE=2'd0, COUNT=2'd1, DONE=2'd2)
  - default CLK_DIV and MAX_COUNT constants
  - a round-robin select function (req, ptr -> one-hot)
- Sub-module tick_gen (parameter CLK_DIV; ports clk, rst, tick): the prescaler. Reused by other slow-rate blocks on the board.
- The arbiter, FSM and counter stay in count_arbiter.

Test Plan (CLK_DIV=4, MAX_COUNT=15, N_REQ=4 unless noted):
- Reset release, req=0 for 100 clks -> tick every 4 clks; grant=0, led=0, busy=0.
- req=4'b0001 held -> first tick: grant=0001, led=0. led increments each tick to 15 over 16 ticks. done=0001 for 1 clk. grant=0 one tick later.
- req=4'b1111 held for 4 runs -> grant order 0001, 0010, 0100, 1000, then 0001 again.
- During a run granted to req[1], pulse req[2] and drop req[1] -> run completes to 15, done[1] pulses; req[2] is not granted unless still high at the IDLE tick.
- Assert rst when led=7 -> same clk: grant=0, led=0, busy=0. No done pulse. After release, next grant goes to req[0] (rr_ptr=0).
- COUNT_ARB_ABORT_EN defined: drop req[0] at led=5 -> at the next tick grant=0, led=0, abort pulses for 1 clk, done stays 0.

Source files
------------

// File: rtl/count_arbiter_pkg.sv
// Shared types and helpers for count_arbiter: FSM state encoding, default
// rates, and the round-robin requester select.
package count_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_CLK_DIV   = 1500000;
  localparam int unsigned DEF_MAX_COUNT = 15;

  // One-hot pick of the first set bit at or above ptr, wrapping modulo n (n <= 8).
  function automatic logic [7:0] rr_select(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int unsigned n);
    logic [7:0] sel;
    logic [3:0] j;
    logic       found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      j = {1'b0, ptr} + 4'(i);
      if (j >= 4'(n)) j = j - 4'(n);
      if (i < n && !found && req[j[2:0]]) begin
        sel[j[2:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/count_arbiter_tick_gen.sv
// Free-running prescaler: tick is a registered one-clk strobe every CLK_DIV clks.
// Shared by the board's slow-rate blocks.
module tick_gen
  import count_arbiter_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/count_arbiter.sv
// Round-robin arbiter sharing one LED counter among N_REQ requesters.
// Define COUNT_ARB_ABORT_EN to abort a run when its request drops (adds abort port).
module count_arbiter
  import count_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned MAX_COUNT = DEF_MAX_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic [CNT_W-1:0] led,
  output logic [N_REQ-1:0] done,
  output logic             tick
`ifdef COUNT_ARB_ABORT_EN
  ,
  output logic             abort
`endif
);

  localparam int unsigned IW = $clog2(N_REQ);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   next_ptr;
  logic [7:0]      sel;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    sel     = rr_select(8'(req), 3'(rr_ptr), N_REQ);
    sel_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sel[i]) sel_idx = IW'(i);
    end
    next_ptr = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gidx   <= '0;
      grant  <= '0;
      led    <= '0;
      done   <= '0;
`ifdef COUNT_ARB_ABORT_EN
      abort  <= 1'b0;
`endif
    end else begin
      done  <= '0;
`ifdef COUNT_ARB_ABORT_EN
      abort <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (tick) begin
            led <= '0;
            if (req != '0) begin
              grant <= sel[N_REQ-1:0];
              gidx  <= sel_idx;
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          if (tick) begin
`ifdef COUNT_ARB_ABORT_EN
            if (!req[gidx]) begin
              grant  <= '0;
              led    <= '0;
              rr_ptr <= next_ptr;
              abort  <= 1'b1;
              state  <= IDLE;
            end else
`endif
            if (led == CNT_W'(MAX_COUNT)) begin
              done  <= grant;
              state <= DONE;
            end else begin
              led <= led + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (tick) begin
            grant  <= '0;
            led    <= '0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          led   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
